// File: rtl/msg_stream_arbiter_pkg.sv
// Shared definitions for the message-stream arbiter slice.
package msg_stream_pkg;

  localparam int DATA_W_DEF  = 64;
  localparam int EMPTY_W_DEF = 3;
  localparam int PORT_IW     = 3;   // port index width, covers up to 8 sources
  localparam int WD_W        = 16;  // watchdog counter width

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/msg_stream_arbiter_if.sv
// Avalon-ST fan-in bundle: NUM_PORTS sources on the s_* side, one sink on m_*.
interface msg_stream_arbiter_if
  import msg_stream_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int EMPTY_W   = EMPTY_W_DEF
);
  logic [NUM_PORTS-1:0]         s_valid;
  logic [NUM_PORTS-1:0]         s_ready;
  logic [NUM_PORTS*DATA_W-1:0]  s_data;
  logic [NUM_PORTS-1:0]         s_startofpacket;
  logic [NUM_PORTS-1:0]         s_endofpacket;
  logic [NUM_PORTS-1:0]         s_error;
  logic [NUM_PORTS*EMPTY_W-1:0] s_empty;

  logic                         m_valid;
  logic                         m_ready;
  logic [DATA_W-1:0]            m_data;
  logic                         m_startofpacket;
  logic                         m_endofpacket;
  logic                         m_error;
  logic [EMPTY_W-1:0]           m_empty;

  // arbiter side
  modport slave (
    input  s_valid, s_data, s_startofpacket, s_endofpacket, s_error, s_empty, m_ready,
    output s_ready, m_valid, m_data, m_startofpacket, m_endofpacket, m_error, m_empty
  );

  // environment side (sources + extractor)
  modport master (
    output s_valid, s_data, s_startofpacket, s_endofpacket, s_error, s_empty, m_ready,
    input  s_ready, m_valid, m_data, m_startofpacket, m_endofpacket, m_error, m_empty
  );
endinterface

// File: rtl/msg_stream_arbiter_rr_arbiter.sv
// Round-robin picker: first requester strictly after last, wrapping.
module rr_arbiter
  import msg_stream_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_IW-1:0]   last,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PORT_IW-1:0]   idx,
  output logic                 any
);

  // scan ports in priority order starting one past last
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      int p;
      p = (int'(last) + i) % NUM_PORTS;
      if (!any && req[p]) begin
        any    = 1'b1;
        gnt[p] = 1'b1;
        idx    = PORT_IW'(p);
      end
    end
  end

endmodule

// File: rtl/msg_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one message extractor.
module msg_stream_arbiter
  import msg_stream_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int EMPTY_W   = EMPTY_W_DEF,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  msg_stream_arbiter_if.slave  bus,
  output logic [PORT_IW-1:0]   grant_id,
  output logic                 busy,
  output logic                 drop_pulse,
  output logic                 timeout_pulse
);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_t           state, state_n;
  logic [PORT_IW-1:0]   last_grant, last_n, grant_n;
  logic [WD_W-1:0]      wd_cnt, wd_n;

  logic [NUM_PORTS-1:0] req, arb_gnt, gsel, stray;
  logic [PORT_IW-1:0]   arb_idx;
  logic                 arb_any;

  logic                 g_valid, g_sop, g_eop, g_err, xfer;
  logic [DATA_W-1:0]    g_data;
  logic [EMPTY_W-1:0]   g_empty;

  assign req   = bus.s_valid & bus.s_startofpacket;
  assign stray = bus.s_valid & ~bus.s_startofpacket;
  assign busy  = (state == LOCK);

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req  (req),
    .last (last_grant),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  // select the granted source's beat
  always_comb begin
    gsel    = '0;
    g_valid = 1'b0;
    g_sop   = 1'b0;
    g_eop   = 1'b0;
    g_err   = 1'b0;
    g_data  = '0;
    g_empty = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_id == PORT_IW'(p)) begin
        gsel[p] = 1'b1;
        g_valid = bus.s_valid[p];
        g_sop   = bus.s_startofpacket[p];
        g_eop   = bus.s_endofpacket[p];
        g_err   = bus.s_error[p];
        g_data  = bus.s_data[p*DATA_W +: DATA_W];
        g_empty = bus.s_empty[p*EMPTY_W +: EMPTY_W];
      end
    end
  end

  assign xfer = busy && ce && !reset && g_valid && bus.m_ready;

  // next state, handshakes, pulses and watchdog
  always_comb begin
    state_n             = state;
    grant_n             = grant_id;
    last_n              = last_grant;
    wd_n                = wd_cnt;
    bus.s_ready         = '0;
    bus.m_valid         = 1'b0;
    bus.m_data          = '0;
    bus.m_startofpacket = 1'b0;
    bus.m_endofpacket   = 1'b0;
    bus.m_error         = 1'b0;
    bus.m_empty         = '0;
    drop_pulse          = 1'b0;
    timeout_pulse       = 1'b0;

    if (state == LOCK) begin
      bus.m_data          = g_data;
      bus.m_startofpacket = g_sop;
      bus.m_endofpacket   = g_eop;
      bus.m_error         = g_err;
      bus.m_empty         = g_empty;
    end

    if (ce && !reset) begin
      case (state)
        IDLE: begin
          // stray mid-packet beats from idle ports are swallowed
          bus.s_ready = stray;
          drop_pulse  = |stray;
          if (arb_any) begin
            state_n = LOCK;
            grant_n = arb_idx;
            wd_n    = '0;
          end
        end
        LOCK: begin
          bus.m_valid = g_valid;
          bus.s_ready = gsel & {NUM_PORTS{bus.m_ready}};
          if (xfer) begin
            wd_n = '0;
            if (g_eop) begin
              last_n  = grant_id;
              state_n = IDLE;
            end
          end else if (wd_cnt >= WD_LAST) begin
            timeout_pulse = 1'b1;
            last_n        = grant_id;
            state_n       = IDLE;
          end else if (wd_cnt != '1) begin
            wd_n = wd_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // state and bookkeeping registers; ce gating is folded into the next-state logic
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= PORT_IW'(NUM_PORTS - 1);
      wd_cnt     <= '0;
    end else begin
      state      <= state_n;
      grant_id   <= grant_n;
      last_grant <= last_n;
      wd_cnt     <= wd_n;
    end
  end

endmodule

// File: tb/tb_msg_stream_arbiter.sv
// Directed bench for msg_stream_arbiter (4 ports, TIMEOUT 1023).
module tb_msg_stream_arbiter;
  import msg_stream_pkg::*;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int EW = 3;

  logic clk = 1'b0;
  logic reset, ce;
  logic [PORT_IW-1:0] grant_id;
  logic busy, drop_pulse, timeout_pulse;
  int nvec = 0;
  int nerr = 0;

  msg_stream_arbiter_if #(.NUM_PORTS(N), .DATA_W(DW), .EMPTY_W(EW)) bus ();

  msg_stream_arbiter #(.NUM_PORTS(N), .DATA_W(DW), .EMPTY_W(EW), .TIMEOUT(1023)) dut (
    .clk           (clk),
    .reset         (reset),
    .ce            (ce),
    .bus           (bus),
    .grant_id      (grant_id),
    .busy          (busy),
    .drop_pulse    (drop_pulse),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int p, input logic v, input logic sop, input logic eop,
                      input logic [63:0] d, input logic [2:0] e);
    bus.s_valid[p]         = v;
    bus.s_startofpacket[p] = sop;
    bus.s_endofpacket[p]   = eop;
    bus.s_error[p]         = 1'b0;
    bus.s_data[p*DW +: DW] = d;
    bus.s_empty[p*EW +: EW] = e;
  endtask

  task automatic clear_all();
    for (int p = 0; p < N; p++) beat(p, 1'b0, 1'b0, 1'b0, 64'h0, 3'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ce = 1'b1;
    bus.m_ready = 1'b1;
    clear_all();
    // stray beat present during reset must not be acknowledged
    beat(2, 1'b1, 1'b0, 1'b0, 64'h55, 3'd0);
    #3;
    chk("rst_m_valid", 64'(bus.m_valid), 64'h0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_grant", 64'(grant_id), 64'h0);
    chk("rst_drop", 64'(drop_pulse), 64'h0);
    chk("rst_m_data", bus.m_data, 64'h0);
    clear_all();
    do_reset();

    // single 3-beat packet on port 0
    beat(0, 1'b1, 1'b1, 1'b0, 64'hD0, 3'd0);
    #1;
    chk("p0_idle_ready", 64'(bus.s_ready), 64'h0);
    chk("p0_idle_mvalid", 64'(bus.m_valid), 64'h0);
    tick();
    chk("p0_busy", 64'(busy), 64'h1);
    chk("p0_grant", 64'(grant_id), 64'h0);
    chk("p0_b0_data", bus.m_data, 64'hD0);
    chk("p0_b0_sop", 64'(bus.m_startofpacket), 64'h1);
    chk("p0_b0_ready", 64'(bus.s_ready), 64'h1);
    tick();
    beat(0, 1'b1, 1'b0, 1'b0, 64'hD1, 3'd0);
    #1;
    chk("p0_b1_data", bus.m_data, 64'hD1);
    chk("p0_b1_valid", 64'(bus.m_valid), 64'h1);
    tick();
    beat(0, 1'b1, 1'b0, 1'b1, 64'hD2, 3'd3);
    #1;
    chk("p0_b2_eop", 64'(bus.m_endofpacket), 64'h1);
    chk("p0_b2_empty", 64'(bus.m_empty), 64'h3);
    tick();
    clear_all();
    #1;
    chk("p0_post_busy", 64'(busy), 64'h0);
    chk("p0_post_mvalid", 64'(bus.m_valid), 64'h0);

    // round robin among 0,1,3 with single-beat packets
    do_reset();
    for (int p = 0; p < N; p++)
      if (p != 2) beat(p, 1'b1, 1'b1, 1'b1, 64'hA0 + 64'(p), 3'd0);
    begin
      int exp_g[6] = '{0, 1, 3, 0, 1, 3};
      for (int k = 0; k < 6; k++) begin
        #1;
        chk("rr_idle_busy", 64'(busy), 64'h0);
        tick();
        chk("rr_grant", 64'(grant_id), 64'(exp_g[k]));
        chk("rr_data", bus.m_data, 64'hA0 + 64'(exp_g[k]));
        tick();
      end
    end
    clear_all();

    // stray non-SOP beat from idle port 2
    beat(2, 1'b1, 1'b0, 1'b0, 64'hBAD, 3'd0);
    #1;
    chk("stray_ready", 64'(bus.s_ready), 64'h4);
    chk("stray_drop", 64'(drop_pulse), 64'h1);
    chk("stray_mvalid", 64'(bus.m_valid), 64'h0);
    tick();
    clear_all();
    #1;
    chk("stray_drop_off", 64'(drop_pulse), 64'h0);
    chk("stray_busy", 64'(busy), 64'h0);

    // watchdog: port 1 granted (last was 3), extractor stalls
    bus.m_ready = 1'b0;
    beat(1, 1'b1, 1'b1, 1'b0, 64'h11, 3'd0);
    beat(2, 1'b1, 1'b1, 1'b0, 64'h22, 3'd0);
    tick();
    chk("wd_grant", 64'(grant_id), 64'h1);
    for (int k = 1; k <= 1023; k++) begin
      if (k == 1 || k == 1022) chk("wd_early", 64'(timeout_pulse), 64'h0);
      if (k == 1023) begin
        chk("wd_pulse", 64'(timeout_pulse), 64'h1);
        chk("wd_busy_at", 64'(busy), 64'h1);
      end
      if (k < 1023) tick();
    end
    tick();
    chk("wd_released", 64'(busy), 64'h0);
    chk("wd_pulse_off", 64'(timeout_pulse), 64'h0);
    tick();
    chk("wd_next_grant", 64'(grant_id), 64'h2);
    beat(1, 1'b0, 1'b0, 1'b0, 64'h0, 3'd0);
    beat(2, 1'b1, 1'b1, 1'b1, 64'h22, 3'd0);
    bus.m_ready = 1'b1;
    tick();
    clear_all();
    #1;
    chk("wd_p2_done", 64'(busy), 64'h0);

    // clock-enable stall mid-packet on port 0
    beat(0, 1'b1, 1'b1, 1'b0, 64'hC0, 3'd0);
    tick();
    chk("ce_grant", 64'(grant_id), 64'h0);
    tick();
    beat(0, 1'b1, 1'b0, 1'b0, 64'hC1, 3'd0);
    ce = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k == 0 || k == 4) begin
        chk("ce_mvalid", 64'(bus.m_valid), 64'h0);
        chk("ce_sready", 64'(bus.s_ready), 64'h0);
        chk("ce_busy", 64'(busy), 64'h1);
      end
      tick();
    end
    ce = 1'b1;
    #1;
    chk("ce_resume_data", bus.m_data, 64'hC1);
    chk("ce_resume_valid", 64'(bus.m_valid), 64'h1);
    tick();
    beat(0, 1'b1, 1'b0, 1'b1, 64'hC2, 3'd0);
    #1;
    chk("ce_last_data", bus.m_data, 64'hC2);
    tick();
    clear_all();
    #1;
    chk("ce_done", 64'(busy), 64'h0);

    // reset mid-packet on port 1 (last grant 0 -> port 1)
    beat(1, 1'b1, 1'b1, 1'b0, 64'hE0, 3'd0);
    tick();
    chk("mr_grant", 64'(grant_id), 64'h1);
    tick();
    beat(1, 1'b1, 1'b0, 1'b0, 64'hE1, 3'd0);
    #2 reset = 1'b1;
    #1;
    chk("mr_mvalid", 64'(bus.m_valid), 64'h0);
    chk("mr_busy", 64'(busy), 64'h0);
    chk("mr_grant0", 64'(grant_id), 64'h0);
    chk("mr_sready", 64'(bus.s_ready), 64'h0);
    chk("mr_mdata", bus.m_data, 64'h0);
    tick();
    #2 reset = 1'b0;
    beat(0, 1'b1, 1'b1, 1'b1, 64'hF0, 3'd0);
    beat(1, 1'b1, 1'b1, 1'b1, 64'hF1, 3'd0);
    tick();
    chk("mr_next_grant", 64'(grant_id), 64'h0);
    chk("mr_next_data", bus.m_data, 64'hF0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/msg_stream_arbiter.md
# msg_stream_arbiter

Packet-granular round-robin arbiter that shares the single 64-bit message extractor input among NUM_PORTS Avalon-ST packet sources. It grants one source at a time on start-of-packet and holds the grant until that packet's end-of-packet beat transfers, so the extractor never sees interleaved packets. It also discards stray non-SOP beats from idle ports and releases a stalled grant after a watchdog timeout.

## Interface
- NUM_PORTS, 4: number of requesting sources (2..8).
- DATA_W, 64: beat width.
- EMPTY_W, 3: empty-field width.
- TIMEOUT, 1023: consecutive no-transfer cycles in LOCK before a forced release (1..65535).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; low = all registers hold, no transfers.
- s_valid  in  NUM_PORTS  per-source valid.
- s_data  in  NUM_PORTS*DATA_W  per-source data; port p at [p*DATA_W +: DATA_W].
- s_startofpacket, s_endofpacket, s_error  in  NUM_PORTS each.
- s_empty  in  NUM_PORTS*EMPTY_W.
- s_ready  out  NUM_PORTS  per-source ready (ready latency 0).
- m_valid, m_startofpacket, m_endofpacket, m_error  out  1  to extractor.
- m_data  out  DATA_W;  m_empty  out  EMPTY_W.
- m_ready  in  1  extractor in_ready.
- grant_id  out  3  currently/last granted port.
- busy  out  1  high in LOCK.
- drop_pulse  out  1  one-cycle pulse per discarded stray beat.
- timeout_pulse  out  1  one-cycle pulse on forced release.

## Operation
- Transfer on any interface = valid & ready & ce at the rising edge.
- States: IDLE, LOCK.
- IDLE: request r[p] = s_valid[p] & s_startofpacket[p]. If any r, select first requesting port strictly after last_grant (wrapping modulo NUM_PORTS), register grant_id, go to LOCK. No beat transfers in IDLE.
- Stray beats in IDLE: s_ready[p] = s_valid[p] & ~s_startofpacket[p]; each such beat is consumed and dropped, drop_pulse = 1 (OR over ports).
- LOCK: m_* = granted port's signals, m_valid = s_valid[g]; s_ready[g] = m_ready; all other s_ready = 0 (non-granted stray beats are not dropped in LOCK).
- LOCK, transfer with s_endofpacket[g]: last_grant <= g, go to IDLE.
- Watchdog: wd_cnt clears on entering LOCK and on each transfer, increments otherwise; at wd_cnt == TIMEOUT-1 with no transfer: timeout_pulse, last_grant <= g, IDLE. Downstream recovery is the system's responsibility.
- SOP beat while already in LOCK (new SOP before EOP): forwarded unchanged; no re-arbitration.
- ce low: m_valid = 0, s_ready = 0, pulses = 0, state/counters hold.
- Reset: state IDLE, grant_id 0, last_grant NUM_PORTS-1 (port 0 wins first), wd_cnt 0, busy 0, pulses 0, all s_ready 0, m_valid 0; m_data/m_empty/m_sop/m_eop/m_error 0. Reset mid-packet abandons the packet; no flush.

## Timing
- Arbitration latency: 1 cycle (request seen in IDLE, first beat may transfer the next cycle).
- Data path combinational (mux only); no added beat latency in LOCK.
- One idle bubble cycle between back-to-back packets (EOP cycle -> IDLE -> LOCK).
- Single-beat packet (SOP & EOP): LOCK for exactly one transfer, then IDLE.
- TIMEOUT width: wd_cnt 16 bits, saturating compare, no wrap.

## Structure
- Shared package msg_stream_pkg: DATA_W, EMPTY_W defaults, state encoding (IDLE=0, LOCK=1), port-index width.
- Sub-module rr_arbiter: request vector + last_grant -> one-hot grant and index; reusable by later multi-extractor schedulers.

## Test plan
- Single source, 3-beat packet on port 0 -> grant_id 0, beats forwarded in order, IDLE for 1 cycle after EOP.
- Ports 0,1,3 request continuously -> grant order 0,1,3,0,1,3; port 2 never granted.
- Port 2 sends valid without SOP in IDLE -> s_ready[2]=1, beat not on m_*, drop_pulse=1 for 1 cycle.
- m_ready held low 1023 cycles in LOCK (TIMEOUT=1023) -> timeout_pulse on cycle 1023, busy drops, next requester granted.
- ce low for 5 cycles mid-packet -> no transfers, wd_cnt frozen, packet resumes intact at ce high.
- reset asserted mid-packet on port 1 -> all outputs to reset values within same cycle; next grant goes to port 0.
